// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Consumer end of the refcpu commit interface. Commit events (pc, target
// register id, written value) are queued in a small FIFO and drained over a
// valid/ready trace port towards the difftest/trace checker. Events offered
// while the queue is full are dropped and flagged by the sticky overflow bit.
//
// Optional feature macro: COMMIT_TRACE_SEQ_EN
//   When defined, every accepted event is stamped with a 16-bit sequence
//   number that is presented on trace_seq alongside the head entry.

module commit_trace_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [4:0]  commit_id,
    input  logic [31:0] commit_data,
    output logic        commit_ready,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [3:0]  trace_wen,
    output logic [4:0]  trace_wnum,
    output logic [31:0] trace_wdata,
`ifdef COMMIT_TRACE_SEQ_EN
    output logic [15:0] trace_seq,
`endif
    output logic        overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      mem_pc   [DEPTH];
    logic [4:0]       mem_id   [DEPTH];
    logic [31:0]      mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [31:0]      held_pc;
    logic [4:0]       held_id;
    logic [31:0]      held_data;

    logic             push;
    logic             pop;

`ifdef COMMIT_TRACE_SEQ_EN
    logic [15:0]      mem_seq [DEPTH];
    logic [15:0]      seq_cnt;
    logic [15:0]      held_seq;
`endif

    // Handshake qualifiers; readiness depends on occupancy only, so a pop in
    // the same cycle never opens room for a push while full
    always_comb begin
        commit_ready = (count != FULL_COUNT);
        trace_valid  = (count != '0);
        push         = commit_valid && commit_ready;
        pop          = trace_valid && trace_ready;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    // Entry storage; an r0 commit is stored with zero data so the retirement
    // is still traced but never looks like an architectural write
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= commit_pc;
            mem_id[wr_ptr]   <= commit_id;
            mem_data[wr_ptr] <= (commit_id == 5'd0) ? 32'd0 : commit_data;
        end
    end

    // Sticky drop flag, cleared only by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (commit_valid && !commit_ready) begin
            overflow <= 1'b1;
        end
    end

    // Copy of the most recently popped head so the trace port keeps showing
    // the last entry once the queue runs empty
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_pc   <= '0;
            held_id   <= '0;
            held_data <= '0;
        end else if (pop) begin
            held_pc   <= mem_pc[rd_ptr];
            held_id   <= mem_id[rd_ptr];
            held_data <= mem_data[rd_ptr];
        end
    end

`ifdef COMMIT_TRACE_SEQ_EN
    // Sequence counter advances only on accepted pushes, so drops leave no gap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seq_cnt  <= '0;
            held_seq <= '0;
        end else begin
            if (push) begin
                seq_cnt <= seq_cnt + 16'd1;
            end
            if (pop) begin
                held_seq <= mem_seq[rd_ptr];
            end
        end
    end

    // Sequence stamp stored next to each entry
    always_ff @(posedge clk) begin
        if (push) begin
            mem_seq[wr_ptr] <= seq_cnt;
        end
    end

    // Head sequence number, held while empty like the other trace fields
    always_comb begin
        trace_seq = trace_valid ? mem_seq[rd_ptr] : held_seq;
    end
`endif

    // Trace port: live head entry while valid, last popped entry otherwise
    always_comb begin
        trace_pc    = trace_valid ? mem_pc[rd_ptr]   : held_pc;
        trace_wnum  = trace_valid ? mem_id[rd_ptr]   : held_id;
        trace_wdata = trace_valid ? mem_data[rd_ptr] : held_data;
        trace_wen   = (trace_wnum != 5'd0) ? 4'hF : 4'h0;
    end

endmodule
